// File: rtl/flash_adc_pkg.sv
// Shared constants and the state encoding for the flash ADC burst sequencer.
package flash_adc_pkg;

  localparam int THERM_W = 32;
  localparam int CODE_W  = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/thermometer_to_binary.sv
// Combinational thermometer-to-binary encoder: the result is the index of the
// highest set bit, or 0 when no bit is set. The encoder does not need a clean
// thermometer word, so a bubble below the top bit does not change the result.
module thermometer_to_binary
  import flash_adc_pkg::*;
(
  input  logic [THERM_W-1:0] therm,
  output logic [CODE_W-1:0]  bin
);

  // Scan upwards so the last set bit seen (the highest one) wins.
  always_comb begin
    bin = '0;
    for (int i = 0; i < THERM_W; i++) begin
      if (therm[i]) bin = CODE_W'(i);
    end
  end

endmodule

// File: rtl/flash_adc_sequencer.sv
// Burst sequencer for the 32-level flash ADC comparator bank.
// It enables the comparators and waits SETTLE_CYCLES. It then captures
// 2^AVG_LOG2 thermometer words, encodes and accumulates them, and presents the
// rounded average on a valid/ready output.
// Optional build macro FLASH_ADC_BUBBLE_CHECK_EN adds a sticky flag for
// non-thermometer captures. When the macro is not defined, bubble_err is tied low.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; comparators off
// SETTLE | comparators on, settle down-counter running
// SAMPLE | one capture into therm_q per cycle, previous capture accumulated
// FLUSH  | comparators off, last capture accumulated
// DONE   | rounded result presented until code_ready
module flash_adc_sequencer
  import flash_adc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int AVG_LOG2      = 2
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [THERM_W-1:0] therm,
  output logic               comp_en,
  output logic               busy,
  output logic [CODE_W-1:0]  code,
  output logic               code_valid,
  input  logic               code_ready,
  output logic               bubble_err
);

  localparam int N     = 1 << AVG_LOG2;
  localparam int ACC_W = CODE_W + AVG_LOG2 + 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SMP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int RND   = (AVG_LOG2 > 0) ? (1 << (AVG_LOG2 - 1)) : 0;

  state_t             state, state_nxt;
  logic [SET_W-1:0]   settle_cnt;
  logic [SMP_W-1:0]   smp_cnt;
  logic [THERM_W-1:0] therm_q;
  logic               cap_vld;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_rnd;
  logic [CODE_W-1:0]  enc;
  logic               add_en;
  logic               burst_start;

  thermometer_to_binary u_thermometer_to_binary (
    .therm (therm_q),
    .bin   (enc)
  );

  // The word captured in a cycle is added one cycle later. The first SAMPLE
  // cycle therefore has nothing to add yet, and FLUSH adds the last capture.
  assign add_en      = ((state == SAMPLE) && cap_vld) || (state == FLUSH);
  assign burst_start = (state == IDLE) && start;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control outputs.
  always_comb begin
    state_nxt  = state;
    comp_en    = 1'b0;
    busy       = 1'b1;
    code_valid = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = SETTLE;
      end
      SETTLE: begin
        comp_en = 1'b1;
        if (settle_cnt == '0) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        comp_en = 1'b1;
        if (smp_cnt == '0) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = DONE;
      DONE: begin
        code_valid = 1'b1;
        if (code_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Timers, capture register and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
      smp_cnt    <= '0;
      therm_q    <= '0;
      cap_vld    <= 1'b0;
      acc        <= '0;
    end else begin
      cap_vld <= (state == SAMPLE);
      if (state == SAMPLE) therm_q <= therm;

      if (burst_start) begin
        settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
      end else if (state == SETTLE) begin
        if (settle_cnt != '0) settle_cnt <= settle_cnt - SET_W'(1);
        else                  smp_cnt    <= SMP_W'(N - 1);
      end else if ((state == SAMPLE) && (smp_cnt != '0)) begin
        smp_cnt <= smp_cnt - SMP_W'(1);
      end

      if (burst_start)  acc <= '0;
      else if (add_en)  acc <= acc + ACC_W'(enc);
    end
  end

  // Round half up. The sum is at most 31*N + N/2, so the shifted value fits in
  // CODE_W bits. The guard bit and the fraction bits are not needed afterwards.
  assign acc_rnd = acc + ACC_W'(RND);
  assign code    = code_valid ? acc_rnd[AVG_LOG2 +: CODE_W] : '0;

  logic rnd_unused;
  assign rnd_unused = ^acc_rnd;

`ifdef FLASH_ADC_BUBBLE_CHECK_EN
  logic bubble_q;

  // Sticky over the burst: a clean thermometer word plus one has no bits in
  // common with the word itself.
  always_ff @(posedge clk) begin
    if (rst)
      bubble_q <= 1'b0;
    else if (burst_start)
      bubble_q <= 1'b0;
    else if (add_en && (|(therm_q & (therm_q + THERM_W'(1)))))
      bubble_q <= 1'b1;
  end

  assign bubble_err = code_valid & bubble_q;
`else
  assign bubble_err = 1'b0;
`endif

endmodule
